// File: rtl/f1_light_seq_if.sv
// Start-light sequencer bus: pacing/trigger/delay handshakes in, light drive out.
interface f1_light_seq_if #(
  parameter int N_LIGHTS = 8
) ();
  logic                en;
  logic                trigger;
  logic                delay_done;
  logic                cmd_seq;
  logic                cmd_delay;
  logic [N_LIGHTS-1:0] data_out;
  logic                busy;
  logic                lights_out;

  // The sequencer itself
  modport slave (
    input  en, trigger, delay_done,
    output cmd_seq, cmd_delay, data_out, busy, lights_out
  );

  // Whatever drives the sequencer (tick source, start button, delay block)
  modport master (
    output en, trigger, delay_done,
    input  cmd_seq, cmd_delay, data_out, busy, lights_out
  );
endinterface

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills lights one per en tick, requests a random
// hold, then blacks all lights out for one cycle. All outputs are Moore.
module f1_light_seq #(
  parameter int N_LIGHTS = 8
) (
  input  logic          clk,
  input  logic          rst,
  f1_light_seq_if.slave bus
);
  localparam int CW = $clog2(N_LIGHTS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_LIGHTS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N_LIGHTS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N_LIGHTS-1:0] therm;

  // State and light-count registers; reset wins over every input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; inputs only matter in the state that consumes them
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        // en in the accepting cycle is deliberately not counted
        if (bus.trigger) begin
          state_d = S_FILL;
          count_d = '0;
        end
      end
      S_FILL: begin
        if (bus.en) begin
          if (count_q == CNT_LAST) begin
            count_d = CNT_FULL;
            state_d = S_ARM;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      S_ARM:  state_d = S_WAIT;
      S_WAIT: if (bus.delay_done) state_d = S_OUT;
      S_OUT: begin
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Thermometer decode of the light count: bit i lit when i < count
  always_comb begin
    therm = '0;
    for (int i = 0; i < N_LIGHTS; i++) therm[i] = (CW'(i) < count_q);
  end

  // Output decode from registered state only
  always_comb begin
    bus.cmd_seq    = 1'b0;
    bus.cmd_delay  = 1'b0;
    bus.busy       = 1'b0;
    bus.lights_out = 1'b0;
    bus.data_out   = '0;
    case (state_q)
      S_IDLE: bus.data_out = therm;
      S_FILL: begin
        bus.cmd_seq  = 1'b1;
        bus.busy     = 1'b1;
        bus.data_out = therm;
      end
      S_ARM: begin
        bus.cmd_delay = 1'b1;
        bus.busy      = 1'b1;
        bus.data_out  = '1;
      end
      S_WAIT: begin
        bus.busy     = 1'b1;
        bus.data_out = '1;
      end
      S_OUT: begin
        bus.busy       = 1'b1;
        bus.lights_out = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: three instances (8, 1, 32 lights) share one stimulus
// stream; a phase-level model predicts every output each cycle, and directed
// literal checks pin the model at key points.
module tb_f1_light_seq;
  logic clk = 1'b0;
  logic rst_s = 1'b1, trig_s = 1'b0, en_s = 1'b0, dd_s = 1'b0;
  int   total = 0, bad = 0;
  bit   chk_on = 1'b0;

  always #5 clk = ~clk;

  f1_light_seq_if #(.N_LIGHTS(8))  if8  ();
  f1_light_seq_if #(.N_LIGHTS(1))  if1  ();
  f1_light_seq_if #(.N_LIGHTS(32)) if32 ();

  assign if8.en  = en_s;  assign if8.trigger  = trig_s; assign if8.delay_done  = dd_s;
  assign if1.en  = en_s;  assign if1.trigger  = trig_s; assign if1.delay_done  = dd_s;
  assign if32.en = en_s;  assign if32.trigger = trig_s; assign if32.delay_done = dd_s;

  f1_light_seq #(.N_LIGHTS(8))  dut8  (.clk(clk), .rst(rst_s), .bus(if8.slave));
  f1_light_seq #(.N_LIGHTS(1))  dut1  (.clk(clk), .rst(rst_s), .bus(if1.slave));
  f1_light_seq #(.N_LIGHTS(32)) dut32 (.clk(clk), .rst(rst_s), .bus(if32.slave));

  logic [31:0] act_do [3];
  logic [3:0]  act_ctl[3];
  assign act_do[0]  = 32'(if8.data_out);
  assign act_do[1]  = 32'(if1.data_out);
  assign act_do[2]  = if32.data_out;
  assign act_ctl[0] = {if8.cmd_seq,  if8.cmd_delay,  if8.busy,  if8.lights_out};
  assign act_ctl[1] = {if1.cmd_seq,  if1.cmd_delay,  if1.busy,  if1.lights_out};
  assign act_ctl[2] = {if32.cmd_seq, if32.cmd_delay, if32.busy, if32.lights_out};

  // Phase-level model: which part of the start procedure each instance is in
  int nl[3] = '{8, 1, 32};
  int lit[3];
  bit filling[3], arming[3], holding[3], blackout[3];

  initial for (int i = 0; i < 3; i++) begin
    lit[i] = 0; filling[i] = 0; arming[i] = 0; holding[i] = 0; blackout[i] = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_s) begin
        lit[i] = 0; filling[i] = 0; arming[i] = 0; holding[i] = 0; blackout[i] = 0;
      end else if (blackout[i]) begin
        blackout[i] = 0; lit[i] = 0;
      end else if (arming[i]) begin
        arming[i] = 0; holding[i] = 1;
      end else if (holding[i]) begin
        if (dd_s) begin holding[i] = 0; blackout[i] = 1; end
      end else if (filling[i]) begin
        if (en_s) begin
          lit[i]++;
          if (lit[i] == nl[i]) begin filling[i] = 0; arming[i] = 1; end
        end
      end else if (trig_s) begin
        filling[i] = 1; lit[i] = 0;
      end
    end
  end

  function automatic logic [31:0] ones(input int n);
    logic [63:0] v;
    v = (64'd1 << n) - 64'd1;
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_do(input int i);
    if (blackout[i]) return 32'd0;
    if (arming[i] || holding[i]) return ones(nl[i]);
    return ones(lit[i]);
  endfunction

  function automatic logic [3:0] exp_ctl(input int i);
    return {filling[i], arming[i],
            filling[i] | arming[i] | holding[i] | blackout[i], blackout[i]};
  endfunction

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (act_do[i] !== exp_do(i) || act_ctl[i] !== exp_ctl(i)) begin
          bad++;
          $display("FAIL model N=%0d t=%0t data_out got %h want %h; seq/dly/busy/lo got %b want %b",
                   nl[i], $time, act_do[i], exp_do(i), act_ctl[i], exp_ctl(i));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic e, input logic d);
    rst_s = r; trig_s = t; en_s = e; dd_s = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low_run;
    bit seen_hi;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_data8", 64'(if8.data_out), 64'h0);
    chk("rst_ctl8", 64'(act_ctl[0]), 64'h0);
    chk_on = 1'b1;

    // Basic sequence, en every 4 cycles, stray trigger and delay_done in FILL
    step(0, 1, 0, 0);
    chk("fill_entry_seq", 64'(if8.cmd_seq), 64'h1);
    chk("fill_entry_data", 64'(if8.data_out), 64'h0);
    for (int k = 1; k <= 8; k++) begin
      step(0, k == 2, 1, k == 3);
      chk("fill_step", 64'(if8.data_out), 64'(ones(k)));
      if (k == 3) chk("fill_07", 64'(if8.data_out), 64'h07);
      if (k < 8) begin
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      end
    end
    chk("arm_delay", 64'(if8.cmd_delay), 64'h1);
    chk("arm_data", 64'(if8.data_out), 64'hFF);
    step(0, 0, 0, 0);
    chk("wait_delay_low", 64'(if8.cmd_delay), 64'h0);
    for (int k = 0; k < 9; k++) step(0, k[0], 1, 0);
    chk("wait_hold", 64'(if8.data_out), 64'hFF);
    step(0, 0, 0, 1);
    chk("out_data", 64'(if8.data_out), 64'h0);
    chk("out_pulse", 64'(if8.lights_out), 64'h1);
    step(0, 0, 0, 0);
    chk("idle_busy", 64'(if8.busy), 64'h0);
    chk("idle_lo", 64'(if8.lights_out), 64'h0);

    // Parameter sweep: continuous en fills N=1 then N=32
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    chk("n1_first_en_data", 64'(if1.data_out), 64'h1);
    chk("n1_arm", 64'(if1.cmd_delay), 64'h1);
    for (int k = 2; k <= 32; k++) step(0, 0, 1, 0);
    chk("n32_arm", 64'(if32.cmd_delay), 64'h1);
    chk("n32_full", 64'(if32.data_out), 64'hFFFF_FFFF);
    step(0, 0, 0, 0);
    chk("n32_wait_full", 64'(if32.data_out), 64'hFFFF_FFFF);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Trigger coincident with en in IDLE does not light anything
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("coinc_data", 64'(if8.data_out), 64'h0);
    step(0, 0, 0, 0);
    chk("coinc_hold", 64'(if8.data_out), 64'h0);
    step(0, 0, 1, 0);
    chk("coinc_first", 64'(if8.data_out), 64'h01);

    // Reset mid-fill with every other input active
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("midfill_07", 64'(if8.data_out), 64'h07);
    step(1, 1, 1, 1);
    chk("midfill_rst_data", 64'(if8.data_out), 64'h0);
    chk("midfill_rst_ctl", 64'(act_ctl[0]), 64'h0);

    // Held trigger (with en and delay_done held): exactly one idle cycle between runs
    low_run = 0;
    seen_hi = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step(0, 1, 1, 1);
      if (!if8.busy) low_run++;
      else begin
        if (seen_hi && low_run > 0) chk("held_gap", 64'(low_run), 64'd1);
        seen_hi = 1'b1;
        low_run = 0;
      end
    end
    step(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
